maze_cursor_ctrl: RTL and testbench
===================================

Name: maze_cursor_ctrl

Overview:
- Upstream stage of the red-square renderer/checkpoint block: produces the 8-bit cursor index `count` (0..197) on the 18-column × 11-row maze grid, or 255 to signal a wall hit.
- Samples four direction pushbuttons once per step tick (10 Hz) and moves one cell per tick while a button is held.
- On a wall hit, holds `count` at 255 for a fixed number of ticks, then respawns at the checkpoint `begin_spot` supplied back by the downstream block.

Parameters:
- TICK_DIV, 625000, CLK cycles per step tick (6.25 MHz / 10 Hz); sims use a small value.
- HIT_TICKS, 10, ticks `count` is held at 255 after a wall hit.
- START_SPOT, 181, cursor index after reset.
- COLS, 18, grid columns (fixed; rows = 11, cells = 198).

Ports:
- CLK  input  1  6.25 MHz system clock.
- RESET  input  1  synchronous, active-high reset.
- btnU  input  1  move up (already synchronised).
- btnD  input  1  move down.
- btnL  input  1  move left.
- btnR  input  1  move right.
- freeze  input  1  high = ignore buttons (cutter screen active).
- mazestate  input  198  bit i = 1 means cell i is path; 0 means wall.
- begin_spot  input  8  respawn index from the downstream checkpoint logic.
- count  output  8  cursor index 0..197, or 255 = hit.
- step_tick  output  1  one-CLK pulse at each step tick.
- game_over  output  1  see Optional Feature.

Behaviour:
- Reset: count=START_SPOT, step_tick=0, game_over=0, tick counter=0, state=PLAY, hit counter=0.
- Tick counter counts 0..TICK_DIV-1 and wraps. step_tick=1 for exactly the cycle in which the counter equals TICK_DIV-1. All moves and state changes below happen only on that cycle.
- Index arithmetic:
  - row = count/18, col = count%18.
  - up = count-18, down = count+18, left = count-1, right = count+1.
  - Computed in 9 bits, so nothing wraps.
- State PLAY:
  - freeze=1 → no change.
  - Otherwise, if any button is held, one direction is taken by priority U > D > L > R.
  - Boundary blocks leave count unchanged and are not hits: U at row 0, D at row 10, L at col 0, R at col 17.
  - Target with mazestate bit 1 → count=target, update visible one cycle after step_tick.
  - Target with mazestate bit 0 → count=255, hit counter=0, go to HIT.
  - No button held → no change.
- State HIT:
  - Each tick increments the hit counter.
  - On the tick where the counter reaches HIT_TICKS-1: count=begin_spot (value sampled that cycle), go to PLAY.
  - Buttons and freeze are ignored in HIT.
- begin_spot out of range (>197) at respawn → count=START_SPOT.
- count never takes a value in 198..254.
- RESET asserted mid-HIT or mid-tick overrides everything; all outputs return to reset values on the next edge.
- Simultaneous opposing buttons (U+D) → U wins, per priority.
- Holding a button gives a 10 Hz auto-repeat; no edge detection.

Optional Feature:
- Macro: MAZE_CURSOR_LIVES_EN.
- Defined:
  - 2-bit lives register, reset to 3.
  - Each PLAY→HIT transition decrements it.
  - When a hit occurs with lives=1: lives=0, count=255 permanently, state=DEAD, game_over=1.
  - Only RESET leaves DEAD.
- Undefined: no lives register, hits are unlimited, game_over is tied to 0.

Test Plan:
- TICK_DIV=4, reset → count=181; step_tick pulses every 4 CLKs (cycles 3, 7, 11…).
- mazestate[163]=1, btnU held for 1 tick → count 181→163 one cycle after step_tick; held 2 ticks with [145]=1 → 145.
- count=0 (reset with START_SPOT=0), btnU and btnL held → count stays 0, no hit.
- mazestate[180]=0, btnL from 181 → count=255 for HIT_TICKS=10 ticks, then count=begin_spot=31; buttons toggled during HIT have no effect.
- freeze=1 with btnR held across 5 ticks → count unchanged; RESET asserted during HIT → count=181 next edge.
- MAZE_CURSOR_LIVES_EN defined: three wall hits → game_over=1 and count fixed at 255 after the 3rd; undefined: game_over stays 0 and respawn repeats.

Source files
------------

// File: rtl/maze_cursor_ctrl.sv
// Maze cursor controller: steps an 18x11 grid index once per tick from held buttons,
// parks at 255 after a wall hit, then respawns. Optional lives/game-over: MAZE_CURSOR_LIVES_EN.
module maze_cursor_ctrl #(
    parameter int unsigned TICK_DIV   = 625000,
    parameter int unsigned HIT_TICKS  = 10,
    parameter int unsigned START_SPOT = 181,
    parameter int unsigned COLS       = 18
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         btnU,
    input  logic         btnD,
    input  logic         btnL,
    input  logic         btnR,
    input  logic         freeze,
    input  logic [197:0] mazestate,
    input  logic [7:0]   begin_spot,
    output logic [7:0]   count,
    output logic         step_tick,
    output logic         game_over
);

    localparam int unsigned ROWS  = 11;
    localparam int unsigned CELLS = COLS * ROWS;
    localparam int unsigned TW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned HW    = (HIT_TICKS > 1) ? $clog2(HIT_TICKS) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HIT_LAST  = HW'(HIT_TICKS - 1);
    localparam logic [7:0]    COLS8     = 8'(COLS);
    localparam logic [7:0]    CELLS8    = 8'(CELLS);
    localparam logic [7:0]    START8    = 8'(START_SPOT);
    localparam logic [7:0]    HIT_IDX   = 8'hFF;

    typedef enum logic [1:0] {StPlay, StHit, StDead} state_e;

    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          step_tick_q, step_tick_d;
    logic [7:0]    count_q, count_d;
    logic [HW-1:0] hit_cnt_q, hit_cnt_d;
    state_e        state_q, state_d;
`ifdef MAZE_CURSOR_LIVES_EN
    logic [1:0]    lives_q, lives_d;
    logic          game_over_q, game_over_d;
`endif

    logic       tick;
    logic [7:0] col;
    logic       at_top, at_bot, at_left, at_right;
    logic       move_req, blocked, path;
    logic [7:0] target;

    always_comb begin
        tick        = (tick_cnt_q == TICK_LAST);
        tick_cnt_d  = tick ? '0 : tick_cnt_q + 1'b1;
        step_tick_d = (tick_cnt_d == TICK_LAST);
    end

    // Target is only consumed when not blocked, so 8-bit arithmetic never wraps where it matters.
    always_comb begin
        col      = count_q % COLS8;
        at_top   = (count_q < COLS8);
        at_bot   = (count_q >= CELLS8 - COLS8);
        at_left  = (col == 8'd0);
        at_right = (col == COLS8 - 8'd1);
        move_req = btnU | btnD | btnL | btnR;
        blocked  = 1'b0;
        target   = count_q;
        if (btnU) begin
            blocked = at_top;
            target  = count_q - COLS8;
        end else if (btnD) begin
            blocked = at_bot;
            target  = count_q + COLS8;
        end else if (btnL) begin
            blocked = at_left;
            target  = count_q - 8'd1;
        end else if (btnR) begin
            blocked = at_right;
            target  = count_q + 8'd1;
        end
        path = mazestate[target];
    end

    always_comb begin
        count_d     = count_q;
        state_d     = state_q;
        hit_cnt_d   = hit_cnt_q;
`ifdef MAZE_CURSOR_LIVES_EN
        lives_d     = lives_q;
        game_over_d = game_over_q;
`endif
        if (tick) begin
            case (state_q)
                StPlay: begin
                    if (!freeze && move_req && !blocked) begin
                        if (path) begin
                            count_d = target;
                        end else begin
                            count_d   = HIT_IDX;
                            hit_cnt_d = '0;
`ifdef MAZE_CURSOR_LIVES_EN
                            if (lives_q == 2'd1) begin
                                lives_d     = 2'd0;
                                game_over_d = 1'b1;
                                state_d     = StDead;
                            end else begin
                                lives_d = lives_q - 2'd1;
                                state_d = StHit;
                            end
`else
                            state_d = StHit;
`endif
                        end
                    end
                end
                StHit: begin
                    if (hit_cnt_q == HIT_LAST) begin
                        count_d   = (begin_spot < CELLS8) ? begin_spot : START8;
                        hit_cnt_d = '0;
                        state_d   = StPlay;
                    end else begin
                        hit_cnt_d = hit_cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            tick_cnt_q  <= '0;
            step_tick_q <= 1'b0;
            count_q     <= START8;
            hit_cnt_q   <= '0;
            state_q     <= StPlay;
`ifdef MAZE_CURSOR_LIVES_EN
            lives_q     <= 2'd3;
            game_over_q <= 1'b0;
`endif
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            step_tick_q <= step_tick_d;
            count_q     <= count_d;
            hit_cnt_q   <= hit_cnt_d;
            state_q     <= state_d;
`ifdef MAZE_CURSOR_LIVES_EN
            lives_q     <= lives_d;
            game_over_q <= game_over_d;
`endif
        end
    end

    assign count     = count_q;
    assign step_tick = step_tick_q;
`ifdef MAZE_CURSOR_LIVES_EN
    assign game_over = game_over_q;
`else
    assign game_over = 1'b0;
`endif

endmodule

// File: tb/tb_maze_cursor_ctrl.sv
// Bench for maze_cursor_ctrl: directed literal checks plus randomized run against a grid model.
module tb_maze_cursor_ctrl;

    localparam int TICK_DIV   = 4;
    localparam int HIT_TICKS  = 10;
    localparam int START_SPOT = 181;
    localparam int NCOLS      = 18;
    localparam int NROWS      = 11;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         bu = 0, bd = 0, bl = 0, br = 0, frz = 0;
    logic [197:0] maze = '1;
    logic [7:0]   bspot = 8'd31;
    logic [7:0]   count;
    logic         step_tick;
    logic         game_over;

    int checks = 0;
    int errors = 0;

    maze_cursor_ctrl #(
        .TICK_DIV  (TICK_DIV),
        .HIT_TICKS (HIT_TICKS),
        .START_SPOT(START_SPOT),
        .COLS      (NCOLS)
    ) dut (
        .CLK       (clk),
        .RESET     (rst),
        .btnU      (bu),
        .btnD      (bd),
        .btnL      (bl),
        .btnR      (br),
        .freeze    (frz),
        .mazestate (maze),
        .begin_spot(bspot),
        .count     (count),
        .step_tick (step_tick),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0=play, 1=waiting out a hit, 2=dead.
    int m_cyc = 0, m_count = 0, m_left = 0, m_lives = 3, m_phase = 0;
    bit m_go = 0, m_valid = 0;

    task automatic model_tick();
        int r, c, tgt;
        bit ok;
        if (m_phase == 0) begin
            if (!frz && (bu || bd || bl || br)) begin
                r  = m_count / NCOLS;
                c  = m_count % NCOLS;
                ok = 1;
                if (bu) begin ok = (r > 0); tgt = m_count - NCOLS; end
                else if (bd) begin ok = (r < NROWS - 1); tgt = m_count + NCOLS; end
                else if (bl) begin ok = (c > 0); tgt = m_count - 1; end
                else begin ok = (c < NCOLS - 1); tgt = m_count + 1; end
                if (ok) begin
                    if (maze[tgt]) m_count = tgt;
                    else begin
                        m_count = 255;
                        m_left  = HIT_TICKS;
                        m_phase = 1;
`ifdef MAZE_CURSOR_LIVES_EN
                        m_lives = m_lives - 1;
                        if (m_lives == 0) begin
                            m_phase = 2;
                            m_go    = 1;
                        end
`endif
                    end
                end
            end
        end else if (m_phase == 1) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_count = (bspot > 197) ? START_SPOT : int'(bspot);
                m_phase = 0;
            end
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_cyc = 0; m_count = START_SPOT; m_left = 0; m_lives = 3; m_phase = 0;
            m_go = 0; m_valid = 1;
        end else if (m_valid) begin
            if (m_cyc == TICK_DIV - 1) model_tick();
            m_cyc = (m_cyc + 1) % TICK_DIV;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("count", {1'b0, count}, 9'(m_count));
            chk("step_tick", {8'd0, step_tick}, 9'(m_cyc == TICK_DIV - 1));
            chk("game_over", {8'd0, game_over}, {8'd0, m_go});
        end
    end

    // Returns at the negedge just after the n-th upcoming tick edge.
    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            while (m_cyc != TICK_DIV - 1) @(negedge clk);
            @(negedge clk);
        end
    endtask

    task automatic set_btn(input logic u, input logic d, input logic l, input logic r);
        bu = u; bd = d; bl = l; br = r;
    endtask

    initial begin
        maze[180] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_count", {1'b0, count}, 9'd181);
        chk("reset_game_over", {8'd0, game_over}, 9'd0);
        @(negedge clk);
        @(negedge clk);
        chk("step_low_cycle2", {8'd0, step_tick}, 9'd0);
        @(negedge clk);
        chk("step_high_cycle3", {8'd0, step_tick}, 9'd1);

        set_btn(1, 0, 0, 0);
        run_ticks(1);
        chk("up_181_163", {1'b0, count}, 9'd163);
        run_ticks(1);
        chk("up_163_145", {1'b0, count}, 9'd145);
        set_btn(0, 1, 0, 0);
        run_ticks(2);
        chk("down_back_181", {1'b0, count}, 9'd181);

        set_btn(0, 0, 1, 0);
        bspot = 8'd31;
        run_ticks(1);
        chk("wall_hit_255", {1'b0, count}, 9'd255);
        for (int i = 0; i < HIT_TICKS - 1; i++) begin
            set_btn(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            frz = 1'($urandom);
            run_ticks(1);
        end
        chk("hit_held_255", {1'b0, count}, 9'd255);
        set_btn(0, 0, 0, 0);
        frz = 1'b0;
        run_ticks(1);
        chk("respawn_31", {1'b0, count}, 9'd31);

        maze[30] = 1'b0;
        bspot = 8'd0;
        set_btn(0, 0, 1, 0);
        run_ticks(1);
        chk("hit2_255", {1'b0, count}, 9'd255);
        set_btn(0, 0, 0, 0);
        run_ticks(HIT_TICKS);
        chk("respawn_0", {1'b0, count}, 9'd0);
        set_btn(1, 0, 1, 0);
        run_ticks(2);
        chk("corner_stay_0", {1'b0, count}, 9'd0);
        chk("corner_no_hit", {8'd0, game_over}, 9'd0);

        set_btn(0, 0, 0, 1);
        frz = 1'b1;
        run_ticks(5);
        chk("freeze_hold_0", {1'b0, count}, 9'd0);
        frz = 1'b0;

        maze[1] = 1'b0;
        bspot = 8'd200;
        run_ticks(1);
        chk("hit3_255", {1'b0, count}, 9'd255);
        set_btn(0, 0, 0, 0);
        run_ticks(HIT_TICKS + 2);
`ifdef MAZE_CURSOR_LIVES_EN
        chk("dead_count", {1'b0, count}, 9'd255);
        chk("dead_game_over", {8'd0, game_over}, 9'd1);
`else
        chk("bad_spot_start", {1'b0, count}, 9'd181);
        chk("no_game_over", {8'd0, game_over}, 9'd0);
`endif

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("reset_again_181", {1'b0, count}, 9'd181);
        set_btn(0, 0, 1, 0);
        run_ticks(1);
        chk("hit4_255", {1'b0, count}, 9'd255);
        set_btn(0, 0, 0, 0);
        run_ticks(3);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_mid_hit", {1'b0, count}, 9'd181);
        chk("reset_mid_hit_step", {8'd0, step_tick}, 9'd0);
        rst = 1'b0;

        for (int i = 0; i < 198; i++) maze[i] = ($urandom_range(0, 4) != 0);
        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(negedge clk);
            set_btn($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
            frz   = ($urandom_range(0, 7) == 0);
            bspot = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(198, 255))
                                                : 8'($urandom_range(0, 197));
            rst   = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 99) == 0) maze[$urandom_range(0, 197)] = 1'($urandom);
        end
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
